// File: rtl/iahb_fetch_master.sv
// ---------------------------------------------------------------------------
// iahb_fetch_master
//
// AHB-Lite master for the instruction fetch path. Each IAHB_access request
// becomes one single-beat 32-bit NONSEQ read. The master waits out slave wait
// states and returns the instruction with a one-cycle valid pulse. ERROR
// responses raise a one-cycle IAHB_error pulse and record the faulting
// address.
//
// Ports
//   cpu_clk, cpu_rstn      clock, asynchronous active-low reset
//   IAHB_access/IAHB_addr  fetch request from imem control (level-held)
//   IAHB_read_data(_valid) fetched instruction, valid for one cycle
//   IAHB_error/err_addr    error pulse and address of last errored fetch
//   HADDR..HPROT           AHB-Lite master address/control outputs
//   HREADY/HRDATA/HRESP    AHB-Lite slave response inputs
// ---------------------------------------------------------------------------
module iahb_fetch_master #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rstn,
    input  logic                   IAHB_access,
    input  logic [ADDR_WIDTH-1:0]  IAHB_addr,
    output logic [INSTR_WIDTH-1:0] IAHB_read_data,
    output logic                   IAHB_read_data_valid,
    output logic                   IAHB_error,
    output logic [ADDR_WIDTH-1:0]  IAHB_err_addr,
    output logic [ADDR_WIDTH-1:0]  HADDR,
    output logic [1:0]             HTRANS,
    output logic                   HWRITE,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic [3:0]             HPROT,
    input  logic                   HREADY,
    input  logic [INSTR_WIDTH-1:0] HRDATA,
    input  logic                   HRESP
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [ADDR_WIDTH-1:0]   haddr_q;
    logic [ADDR_WIDTH-1:0]   err_addr_q;
    logic [ADDR_WIDTH-1:0]   fetch_addr;
    logic                    addr_phase;
    logic                    accept;
    logic                    complete_ok;
    logic                    complete_err;
    logic                    unused_addr_lsbs;

    // Byte offset of the pc is irrelevant for word fetches.
    assign fetch_addr       = {IAHB_addr[ADDR_WIDTH-1:2], 2'b00};
    assign unused_addr_lsbs = ^IAHB_addr[1:0];

    assign HWRITE = 1'b0;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0010;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            req_addr   <= '0;
            haddr_q    <= '0;
            err_addr_q <= '0;
        end else begin
            if (addr_phase) begin
                haddr_q <= fetch_addr;
            end
            if (accept) begin
                req_addr <= fetch_addr;
            end
            if (complete_err) begin
                err_addr_q <= req_addr;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        addr_phase   = 1'b0;
        accept       = 1'b0;
        complete_ok  = 1'b0;
        complete_err = 1'b0;
        case (state)
            ST_IDLE: begin
                // Qualified by reset so HTRANS reads IDLE while reset is held,
                // even if the requester keeps IAHB_access high.
                addr_phase = IAHB_access && cpu_rstn;
                accept     = addr_phase && HREADY;
                if (accept) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_nxt = ST_IDLE;
                    if (HRESP) begin
                        complete_err = 1'b1;
                    end else begin
                        // Drop the beat if the pc moved on or the request went away.
                        complete_ok = IAHB_access &&
                                      (IAHB_addr[ADDR_WIDTH-1:2] == req_addr[ADDR_WIDTH-1:2]);
                    end
                end else if (HRESP) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    state_nxt    = ST_IDLE;
                    complete_err = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign HTRANS = addr_phase ? 2'b10 : 2'b00;
    assign HADDR  = addr_phase ? fetch_addr : haddr_q;

    assign IAHB_read_data_valid = complete_ok;
    assign IAHB_read_data       = complete_ok ? HRDATA : '0;
    assign IAHB_error           = complete_err;
    // The errored address is visible in the pulse cycle and held afterwards.
    assign IAHB_err_addr        = complete_err ? req_addr : err_addr_q;

endmodule

// File: tb/tb_iahb_fetch_master.sv
module tb_iahb_fetch_master;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn = 1'b0;
    logic        IAHB_access = 1'b0;
    logic [31:0] IAHB_addr = '0;
    logic [31:0] IAHB_read_data;
    logic        IAHB_read_data_valid;
    logic        IAHB_error;
    logic [31:0] IAHB_err_addr;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = '0;
    logic        HRESP = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vcnt = 0;
    logic [31:0] last_err = '0;
    logic [31:0] last_haddr = '0;

    iahb_fetch_master #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .cpu_clk(cpu_clk),
        .cpu_rstn(cpu_rstn),
        .IAHB_access(IAHB_access),
        .IAHB_addr(IAHB_addr),
        .IAHB_read_data(IAHB_read_data),
        .IAHB_read_data_valid(IAHB_read_data_valid),
        .IAHB_error(IAHB_error),
        .IAHB_err_addr(IAHB_err_addr),
        .HADDR(HADDR),
        .HTRANS(HTRANS),
        .HWRITE(HWRITE),
        .HSIZE(HSIZE),
        .HBURST(HBURST),
        .HPROT(HPROT),
        .HREADY(HREADY),
        .HRDATA(HRDATA),
        .HRESP(HRESP)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) cyc <= cyc + 1;
    always @(negedge cpu_clk) if (IAHB_read_data_valid === 1'b1) vcnt <= vcnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, {31'b0, IAHB_read_data_valid}, 32'd0);
        chk({tag, "_error"}, {31'b0, IAHB_error}, 32'd0);
        chk({tag, "_rdata"}, IAHB_read_data, 32'd0);
    endtask

    // One idle cycle with no request: bus idle, address held, nothing reported.
    task automatic idle(input string tag);
        IAHB_access = 1'b0;
        HREADY = 1'b1;
        HRESP = 1'b0;
        @(negedge cpu_clk);
        chk({tag, "_htrans"}, {30'b0, HTRANS}, 32'd0);
        chk({tag, "_haddr"}, HADDR, last_haddr);
        chk({tag, "_erraddr"}, IAHB_err_addr, last_err);
        chk_quiet(tag);
        next_cycle();
    endtask

    // One complete fetch transaction as seen from the slave side.
    // aw: address-phase stalls, waits: data-phase wait states,
    // kind: 0 OKAY, 1 two-cycle ERROR, 2 ERROR without first cycle,
    // redir: pc changes to raddr at start of data phase.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input int aw, input int waits, input int kind,
                         input bit redir, input logic [31:0] raddr);
        logic [31:0] al;
        bit          exp_valid;
        al = {a[31:2], 2'b00};
        IAHB_access = 1'b1;
        IAHB_addr = a;
        HRESP = 1'b0;
        for (int i = 0; i < aw; i++) begin
            HREADY = 1'b0;
            HRDATA = $urandom;
            @(negedge cpu_clk);
            chk({tag, "_stall_htrans"}, {30'b0, HTRANS}, 32'd2);
            chk({tag, "_stall_haddr"}, HADDR, al);
            chk_quiet({tag, "_stall"});
            next_cycle();
        end
        HREADY = 1'b1;
        @(negedge cpu_clk);
        chk({tag, "_c0_htrans"}, {30'b0, HTRANS}, 32'd2);
        chk({tag, "_c0_haddr"}, HADDR, al);
        chk_quiet({tag, "_c0"});
        next_cycle();
        last_haddr = al;
        if (redir) IAHB_addr = raddr;
        for (int i = 0; i < waits; i++) begin
            HREADY = 1'b0;
            HRESP = 1'b0;
            HRDATA = $urandom;
            @(negedge cpu_clk);
            chk({tag, "_wait_htrans"}, {30'b0, HTRANS}, 32'd0);
            chk({tag, "_wait_haddr"}, HADDR, al);
            chk_quiet({tag, "_wait"});
            next_cycle();
        end
        if (kind == 0) begin
            HREADY = 1'b1;
            HRESP = 1'b0;
            HRDATA = d;
            exp_valid = !redir || (raddr[31:2] == a[31:2]);
            @(negedge cpu_clk);
            chk({tag, "_done_valid"}, {31'b0, IAHB_read_data_valid}, {31'b0, exp_valid});
            chk({tag, "_done_rdata"}, IAHB_read_data, exp_valid ? d : 32'd0);
            chk({tag, "_done_error"}, {31'b0, IAHB_error}, 32'd0);
            chk({tag, "_done_erraddr"}, IAHB_err_addr, last_err);
        end else begin
            if (kind == 1) begin
                HREADY = 1'b0;
                HRESP = 1'b1;
                @(negedge cpu_clk);
                chk({tag, "_err1_htrans"}, {30'b0, HTRANS}, 32'd0);
                chk_quiet({tag, "_err1"});
                next_cycle();
            end
            HREADY = 1'b1;
            HRESP = 1'b1;
            HRDATA = $urandom;
            @(negedge cpu_clk);
            chk({tag, "_err_pulse"}, {31'b0, IAHB_error}, 32'd1);
            chk({tag, "_err_valid"}, {31'b0, IAHB_read_data_valid}, 32'd0);
            chk({tag, "_err_rdata"}, IAHB_read_data, 32'd0);
            chk({tag, "_err_addr"}, IAHB_err_addr, al);
            last_err = al;
        end
        chk({tag, "_done_htrans"}, {30'b0, HTRANS}, 32'd0);
        next_cycle();
        HREADY = 1'b1;
        HRESP = 1'b0;
    endtask

    initial begin
        int start_cyc;
        int start_v;
        logic [31:0] ra;
        logic [31:0] rr;

        // Reset values, with constants valid during reset.
        #12;
        chk("rst_htrans", {30'b0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_erraddr", IAHB_err_addr, 32'd0);
        chk_quiet("rst");
        chk("rst_hwrite", {31'b0, HWRITE}, 32'd0);
        chk("rst_hsize", {29'b0, HSIZE}, 32'd2);
        chk("rst_hburst", {29'b0, HBURST}, 32'd0);
        chk("rst_hprot", {28'b0, HPROT}, 32'd2);
        next_cycle();
        cpu_rstn = 1'b1;
        idle("post_rst");

        // Zero-wait fetch.
        fetch("zw", 32'h0000_1004, 32'h0000_0013, 0, 0, 0, 1'b0, 32'h0);
        idle("zw_after");

        // Three wait states; valid exactly in cycle 4.
        fetch("ws", 32'h0000_1008, 32'hCAFE_0001, 0, 3, 0, 1'b0, 32'h0);
        idle("ws_after");

        // Address phase stalled by HREADY low.
        fetch("astall", 32'h0000_2010, 32'h1234_5678, 2, 1, 0, 1'b0, 32'h0);
        idle("astall_after");

        // Two-cycle error response.
        fetch("err2", 32'h2000_0008, 32'hDEAD_BEEF, 0, 0, 1, 1'b0, 32'h0);
        idle("err2_after");

        // Stale discard, then the redirected fetch.
        fetch("stale", 32'h0000_0100, 32'h0BAD_0100, 0, 3, 0, 1'b1, 32'h0000_0200);
        fetch("redir", 32'h0000_0200, 32'h600D_0200, 0, 0, 0, 1'b0, 32'h0);
        idle("redir_after");

        // Back-to-back fetches: three valids in six cycles.
        start_cyc = cyc;
        start_v = vcnt;
        fetch("b2b0", 32'h0000_0000, 32'h1111_0000, 0, 0, 0, 1'b0, 32'h0);
        fetch("b2b1", 32'h0000_0004, 32'h1111_0004, 0, 0, 0, 1'b0, 32'h0);
        fetch("b2b2", 32'h0000_0008, 32'h1111_0008, 0, 0, 0, 1'b0, 32'h0);
        chk("b2b_cycles", 32'(cyc - start_cyc), 32'd6);
        chk("b2b_valids", 32'(vcnt - start_v), 32'd3);
        idle("b2b_after");

        // Error without a first error cycle, misaligned pc.
        fetch("err1", 32'h0000_0443, 32'h0, 0, 2, 2, 1'b0, 32'h0);
        idle("err1_after");

        // Reset during a wait state.
        IAHB_access = 1'b1;
        IAHB_addr = 32'h0000_0300;
        HREADY = 1'b1;
        next_cycle();
        HREADY = 1'b0;
        #2;
        cpu_rstn = 1'b0;
        #1;
        chk("arst_htrans", {30'b0, HTRANS}, 32'd0);
        chk("arst_haddr", HADDR, 32'd0);
        chk("arst_erraddr", IAHB_err_addr, 32'd0);
        chk_quiet("arst");
        last_err = '0;
        last_haddr = '0;
        next_cycle();
        HREADY = 1'b1;
        HRDATA = 32'hFFFF_0300;
        @(negedge cpu_clk);
        chk_quiet("arst_late_ready");
        next_cycle();
        IAHB_access = 1'b0;
        cpu_rstn = 1'b1;
        idle("arst_rel0");
        idle("arst_rel1");

        // Randomized transactions against the transaction-level expectations.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom & 32'h000F_FFFF;
            rr = ($urandom_range(0, 1) == 0) ? (ra ^ 32'h0000_0003) : (ra + 32'h0000_0004);
            fetch("rnd", ra, $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
                  ($urandom_range(0, 4) < 3) ? 0 : $urandom_range(1, 2),
                  ($urandom_range(0, 3) == 0), rr);
            if ($urandom_range(0, 2) == 0) idle("rnd_idle");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iahb_fetch_master.md
# iahb_fetch_master

AHB-Lite master for the instruction fetch path: it is the responder side of the IAHB request interface driven by the instruction memory controller. It turns each `IAHB_access`/`IAHB_addr` request into a single-beat 32-bit NONSEQ read, waits out slave wait states, and returns `IAHB_read_data` with a one-cycle `IAHB_read_data_valid`. Error responses are recorded and reported separately. The block sits between the core's fetch/imem control and the system instruction AHB bus.

## Interface
- `ADDR_WIDTH`, `` `ADDR_WIDTH `` (32): request and HADDR width.
- `INSTR_WIDTH`, `` `INSTR_WIDTH `` (32): instruction and HRDATA width.

Ports (clock and reset first):
- `cpu_clk`  in  1  CPU clock; the only clock.
- `cpu_rstn`  in  1  asynchronous, active-low reset.
- `IAHB_access`  in  1  fetch request; level-held until served.
- `IAHB_addr`  in  ADDR_WIDTH  fetch address (current pc).
- `IAHB_read_data`  out  INSTR_WIDTH  fetched instruction; 0 when not valid.
- `IAHB_read_data_valid`  out  1  one-cycle pulse, data valid.
- `IAHB_error`  out  1  one-cycle pulse on completed ERROR response.
- `IAHB_err_addr`  out  ADDR_WIDTH  address of the last errored fetch.
- `HADDR`  out  ADDR_WIDTH  AHB address; bits [1:0] always 0.
- `HTRANS`  out  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- `HWRITE`  out  1  constant 0.
- `HSIZE`  out  3  constant 3'b010 (word).
- `HBURST`  out  3  constant 3'b000 (SINGLE).
- `HPROT`  out  4  constant 4'b0010 (opcode fetch, privileged, non-bufferable, non-cacheable).
- `HREADY`  in  1  bus ready.
- `HRDATA`  in  INSTR_WIDTH  read data.
- `HRESP`  in  1  0 = OKAY, 1 = ERROR.

## Operation
- FSM states: `ST_IDLE`, `ST_DATA`, `ST_ERR`. Reset state is `ST_IDLE`.
- `ST_IDLE`:
  - `HTRANS` = NONSEQ when `IAHB_access`, else IDLE.
  - `HADDR` = {`IAHB_addr`[31:2], 2'b00} when `IAHB_access`; otherwise it holds its last value.
  - Transfer is accepted when `IAHB_access && HREADY`. On acceptance, latch the address into `req_addr` and go to `ST_DATA`.
  - If `HREADY` is low, stay in `ST_IDLE` and keep driving the address phase.
- `ST_DATA`:
  - Drives HTRANS=IDLE; no pipelined next address.
  - `HREADY`=0, `HRESP`=0: wait state; stay.
  - `HREADY`=0, `HRESP`=1: first error cycle; go to `ST_ERR`.
  - `HREADY`=1, `HRESP`=0: completion. If `IAHB_access` && `IAHB_addr`[31:2]==`req_addr`[31:2], pulse valid with `HRDATA`. Otherwise discard silently (stale: pc redirected or request dropped). Go to `ST_IDLE`.
  - `HREADY`=1, `HRESP`=1 without a preceding first error cycle: treat as error. Pulse `IAHB_error`, load `IAHB_err_addr`, go to `ST_IDLE`.
- `ST_ERR`:
  - Drives HTRANS=IDLE.
  - Waits for `HREADY`=1. Then pulse `IAHB_error`, set `IAHB_err_addr` = `req_addr`, no valid, go to `ST_IDLE`.
- Valid and error never assert in the same cycle.
- After completion, the next fetch is not issued in the same cycle. This is decided: the pc advances the cycle after valid.

## Timing
- Reset values: `HTRANS`=0, `HADDR`=0, `IAHB_read_data`=0, `IAHB_read_data_valid`=0, `IAHB_error`=0, `IAHB_err_addr`=0, `req_addr`=0. Constants (`HWRITE`, `HSIZE`, `HBURST`, `HPROT`) are valid during reset.
- Zero-wait latency:
  - Cycle 0: address phase, accepted.
  - Cycle 1: data phase; `HRDATA` is passed through combinationally and valid is high.
  - Cycle 2: earliest next NONSEQ.
  - Peak rate is one instruction per 2 cycles; each wait state adds 1 cycle.
- `IAHB_read_data_valid` and `IAHB_read_data` are combinational from `HREADY`/`HRDATA` in `ST_DATA`. `IAHB_error` is likewise combinational in the completing cycle.
- `HADDR`/`HTRANS` stay stable while an address phase is pending with `HREADY` low.
- Reset mid-transfer: the FSM returns to `ST_IDLE` immediately and `HTRANS`=IDLE. Any later `HREADY` for the aborted beat is ignored.
- Misaligned `IAHB_addr`: bits [1:0] are ignored and not reported.

## Test plan
- Zero-wait fetch:
  - Stimulus: `IAHB_access`=1, addr 0x0000_1004, `HRDATA`=0x0000_0013, `HREADY` always 1.
  - Required: HTRANS=NONSEQ and HADDR=0x1004 in cycle 0; valid with data 0x13 in cycle 1; HTRANS=IDLE in cycle 1.
- Wait states:
  - Stimulus: `HREADY` low for 3 data-phase cycles.
  - Required: valid appears exactly in cycle 4, single pulse; HADDR unchanged throughout.
- Two-cycle error:
  - Stimulus: addr 0x2000_0008, slave returns HRESP=1 with `HREADY`=0, then HRESP=1 with `HREADY`=1.
  - Required: `IAHB_error` pulse in the second cycle; `IAHB_err_addr`=0x2000_0008; no valid; FSM back to idle.
- Stale discard:
  - Stimulus: `IAHB_addr` changes from 0x100 to 0x200 during wait states.
  - Required: no valid for 0x100. The next NONSEQ is to 0x200 and returns valid.
- Back-to-back:
  - Stimulus: `IAHB_access` held high while pc increments by 4 after each valid.
  - Required: NONSEQ every 2 cycles with addresses 0x0, 0x4, 0x8; 3 valid pulses in 6 cycles.
- Reset mid-op:
  - Stimulus: assert `cpu_rstn`=0 during a wait state.
  - Required: all outputs take reset values asynchronously; no valid after release until a new request.
